// File: rtl/nibble_stack_writer_pkg.sv
// Shared opcode encodings and size defaults for the nibble stack and the opcode decoder.
// Pure declarations: no logic, no latency, no flow control.
package nibble_stack_writer_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

endpackage

// File: rtl/nibble_stack_writer_slot_reg.sv
// One stack slot: WIDTH-bit register with synchronous load and zero (zero wins).
// Latency 1; no backpressure, updates whenever an enable is high.
module nibble_slot_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             zero,
  input  logic [WIDTH-1:0] load_dat,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] val_d;
  logic [WIDTH-1:0] val_q;

  always_comb begin
    val_d = val_q;
    if (zero) begin
      val_d = '0;
    end else if (load) begin
      val_d = load_dat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/nibble_stack_writer.sv
// LIFO of WIDTH-bit values in DEPTH slots, every slot exposed; push/pop/replace/clear.
// Latency 1 (state visible the cycle after the command); never stalls, one command per cycle.
module nibble_stack_writer
  import nibble_stack_writer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic [1:0]             cmd_op,
  input  logic [WIDTH-1:0]       cmd_data,
  input  logic                   clear,
  output logic [DEPTH*WIDTH-1:0] slots,
  output logic [WIDTH-1:0]       top,
  output logic [PTR_W-1:0]       top_idx,
  output logic [PTR_W:0]         depth,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
);

  localparam logic [PTR_W:0] DEPTH_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0] DEPTH_FULL = (PTR_W+1)'(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || (1 << PTR_W) != DEPTH) begin : g_bad_depth
      $error("nibble_stack_writer: DEPTH must be a power of two >= 2 with PTR_W = log2(DEPTH)");
    end
  endgenerate

  logic [PTR_W:0] depth_d;
  logic [PTR_W:0] depth_q;
  logic           overflow_d;
  logic           overflow_q;
  logic           underflow_d;
  logic           underflow_q;

  logic           push_ok;
  logic           pop_ok;
  logic           replace_ok;
  logic [PTR_W:0] depth_m1;

  logic [WIDTH-1:0] slot_val [DEPTH];

  assign empty    = (depth_q == '0);
  assign full     = (depth_q == DEPTH_FULL);
  assign depth_m1 = depth_q - DEPTH_ONE;

  always_comb begin
    push_ok     = 1'b0;
    pop_ok      = 1'b0;
    replace_ok  = 1'b0;
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (clear) begin
      depth_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (cmd_valid) begin
      case (op_e'(cmd_op))
        OP_PUSH: begin
          if (full) begin
            overflow_d = 1'b1;
          end else begin
            push_ok = 1'b1;
            depth_d = depth_q + DEPTH_ONE;
          end
        end
        OP_POP: begin
          if (empty) begin
            underflow_d = 1'b1;
          end else begin
            pop_ok  = 1'b1;
            depth_d = depth_m1;
          end
        end
        OP_REPLACE: begin
          if (empty) begin
            underflow_d = 1'b1;
          end else begin
            replace_ok = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Push writes the slot at depth; replace and pop act on the current top (depth-1).
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      logic slot_load;
      logic slot_zero;

      assign slot_load = (push_ok    && depth_q  == (PTR_W+1)'(i)) ||
                         (replace_ok && depth_m1 == (PTR_W+1)'(i));
      assign slot_zero = clear || (pop_ok && depth_m1 == (PTR_W+1)'(i));

      nibble_slot_reg #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk      (clk),
        .reset    (reset),
        .load     (slot_load),
        .zero     (slot_zero),
        .load_dat (cmd_data),
        .q        (slot_val[i])
      );

      assign slots[i*WIDTH +: WIDTH] = slot_val[i];
    end
  endgenerate

  assign top_idx   = empty ? '0 : depth_m1[PTR_W-1:0];
  assign top       = empty ? '0 : slot_val[top_idx];
  assign depth     = depth_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_nibble_stack_writer.sv
// Directed-vector bench for nibble_stack_writer: each task drives a scenario and checks hand-computed results.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too, away from the edge.
module tb_nibble_stack_writer;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  localparam logic [1:0] C_NOP     = 2'b00;
  localparam logic [1:0] C_PUSH    = 2'b01;
  localparam logic [1:0] C_POP     = 2'b10;
  localparam logic [1:0] C_REPLACE = 2'b11;

  logic                   clk;
  logic                   reset;
  logic                   cmd_valid;
  logic [1:0]             cmd_op;
  logic [WIDTH-1:0]       cmd_data;
  logic                   clear;
  logic [DEPTH*WIDTH-1:0] slots;
  logic [WIDTH-1:0]       top;
  logic [PTR_W-1:0]       top_idx;
  logic [PTR_W:0]         depth;
  logic                   empty;
  logic                   full;
  logic                   overflow;
  logic                   underflow;

  int vectors;
  int miscompares;

  nibble_stack_writer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .clear     (clear),
    .slots     (slots),
    .top       (top),
    .top_idx   (top_idx),
    .depth     (depth),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic vld, input logic [1:0] op, input logic [3:0] dat, input logic clr);
    cmd_valid = vld;
    cmd_op    = op;
    cmd_data  = dat;
    clear     = clr;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = C_NOP;
    cmd_data  = '0;
    clear     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cmd_valid = 1'b0;
    cmd_op    = C_NOP;
    cmd_data  = '0;
    clear     = 1'b0;
    do_reset();
    vectors++;
    if ({depth, top, top_idx, empty, full, overflow, underflow} !== {4'd0, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_status: depth=%0d top=%h idx=%0d e=%b f=%b ov=%b un=%b, want 0/0/0/1/0/0/0",
               depth, top, top_idx, empty, full, overflow, underflow);
    end
    vectors++;
    if (slots !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_slots: got %h want 00000000", slots);
    end
  endtask

  task automatic test_push_pop_replace();
    do_reset();
    step(1'b1, C_PUSH, 4'h3, 1'b0);
    vectors++;
    if ({depth, top, top_idx} !== {4'd1, 4'h3, 3'd0}) begin
      miscompares++;
      $display("FAIL push1_latency: depth=%0d top=%h idx=%0d want 1/3/0", depth, top, top_idx);
    end
    step(1'b1, C_PUSH, 4'h7, 1'b0);
    step(1'b1, C_PUSH, 4'hA, 1'b0);
    vectors++;
    if ({depth, top, top_idx, empty, full} !== {4'd3, 4'hA, 3'd2, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL push3_status: depth=%0d top=%h idx=%0d e=%b f=%b want 3/a/2/0/0",
               depth, top, top_idx, empty, full);
    end
    vectors++;
    if (slots[11:0] !== 12'hA73 || slots[31:12] !== 20'h0) begin
      miscompares++;
      $display("FAIL push3_slots: got %h want 00000a73", slots);
    end
    step(1'b1, C_POP, 4'hE, 1'b0);
    vectors++;
    if ({depth, top, top_idx} !== {4'd2, 4'h7, 3'd1} || slots !== 32'h0000_0073) begin
      miscompares++;
      $display("FAIL pop_clears_slot: depth=%0d top=%h idx=%0d slots=%h want 2/7/1/00000073",
               depth, top, top_idx, slots);
    end
    step(1'b1, C_REPLACE, 4'h5, 1'b0);
    vectors++;
    if ({depth, top, top_idx} !== {4'd2, 4'h5, 3'd1} || slots !== 32'h0000_0053) begin
      miscompares++;
      $display("FAIL replace_top: depth=%0d top=%h idx=%0d slots=%h want 2/5/1/00000053",
               depth, top, top_idx, slots);
    end
    vectors++;
    if ({overflow, underflow} !== 2'b00) begin
      miscompares++;
      $display("FAIL flags_quiet: ov=%b un=%b want 0/0", overflow, underflow);
    end
  endtask

  task automatic test_hold();
    // Stack holds 3,5 from the previous scenario.
    step(1'b1, C_NOP, 4'hF, 1'b0);
    step(1'b0, C_PUSH, 4'hF, 1'b0);
    step(1'b0, C_POP, 4'h0, 1'b0);
    vectors++;
    if (depth !== 4'd2 || slots !== 32'h0000_0053 || top !== 4'h5) begin
      miscompares++;
      $display("FAIL hold_state: depth=%0d top=%h slots=%h want 2/5/00000053", depth, top, slots);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, C_PUSH, 4'(i), 1'b0);
    vectors++;
    if ({depth, full, empty, top, top_idx, overflow} !== {4'd8, 1'b1, 1'b0, 4'h8, 3'd7, 1'b0}) begin
      miscompares++;
      $display("FAIL fill_status: depth=%0d f=%b e=%b top=%h idx=%0d ov=%b want 8/1/0/8/7/0",
               depth, full, empty, top, top_idx, overflow);
    end
    step(1'b1, C_PUSH, 4'hF, 1'b0);
    vectors++;
    if ({depth, full, overflow} !== {4'd8, 1'b1, 1'b1} || slots !== 32'h8765_4321) begin
      miscompares++;
      $display("FAIL overflow_push: depth=%0d f=%b ov=%b slots=%h want 8/1/1/87654321",
               depth, full, overflow, slots);
    end
    step(1'b1, C_POP, 4'h0, 1'b0);
    vectors++;
    if ({depth, full, overflow, top, top_idx} !== {4'd7, 1'b0, 1'b1, 4'h7, 3'd6} || slots !== 32'h0765_4321) begin
      miscompares++;
      $display("FAIL overflow_sticky: depth=%0d f=%b ov=%b top=%h idx=%0d slots=%h want 7/0/1/7/6/07654321",
               depth, full, overflow, top, top_idx, slots);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    step(1'b1, C_POP, 4'h0, 1'b0);
    vectors++;
    if ({depth, underflow, empty} !== {4'd0, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL underflow_pop: depth=%0d un=%b e=%b want 0/1/1", depth, underflow, empty);
    end
    step(1'b1, C_REPLACE, 4'h9, 1'b0);
    vectors++;
    if ({depth, underflow, overflow, top, top_idx} !== {4'd0, 1'b1, 1'b0, 4'h0, 3'd0} || slots !== 32'h0) begin
      miscompares++;
      $display("FAIL underflow_replace: depth=%0d un=%b ov=%b top=%h idx=%0d slots=%h want 0/1/0/0/0/00000000",
               depth, underflow, overflow, top, top_idx, slots);
    end
    step(1'b1, C_PUSH, 4'h4, 1'b0);
    vectors++;
    if ({depth, top, underflow} !== {4'd1, 4'h4, 1'b1}) begin
      miscompares++;
      $display("FAIL underflow_sticky: depth=%0d top=%h un=%b want 1/4/1", depth, top, underflow);
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, C_PUSH, 4'(i), 1'b0);
    step(1'b1, C_PUSH, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, C_POP, 4'h0, 1'b0);
    vectors++;
    if ({depth, overflow} !== {4'd4, 1'b1} || slots !== 32'h0000_4321) begin
      miscompares++;
      $display("FAIL clear_setup: depth=%0d ov=%b slots=%h want 4/1/00004321", depth, overflow, slots);
    end
    step(1'b1, C_PUSH, 4'hC, 1'b1);
    vectors++;
    if ({depth, overflow, underflow, empty, top} !== {4'd0, 1'b0, 1'b0, 1'b1, 4'h0} || slots !== 32'h0) begin
      miscompares++;
      $display("FAIL clear_discards_push: depth=%0d ov=%b un=%b e=%b top=%h slots=%h want 0/0/0/1/0/00000000",
               depth, overflow, underflow, empty, top, slots);
    end
    step(1'b1, C_PUSH, 4'hC, 1'b0);
    vectors++;
    if (depth !== 4'd1 || slots !== 32'h0000_000C) begin
      miscompares++;
      $display("FAIL push_after_clear: depth=%0d slots=%h want 1/0000000c", depth, slots);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, C_PUSH, 4'h2, 1'b0);
    step(1'b1, C_PUSH, 4'hB, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = C_PUSH;
    cmd_data  = 4'h6;
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if ({depth, top, top_idx, empty, full} !== {4'd0, 4'h0, 3'd0, 1'b1, 1'b0} || slots !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset_immediate: depth=%0d top=%h idx=%0d e=%b f=%b slots=%h want 0/0/0/1/0/00000000",
               depth, top, top_idx, empty, full, slots);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = C_NOP;
    cmd_data  = '0;
    reset     = 1'b0;
    step(1'b0, C_NOP, 4'h0, 1'b0);
    vectors++;
    if (depth !== 4'd0 || slots[3:0] !== 4'h0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset_after: depth=%0d slot0=%h e=%b want 0/0/1", depth, slots[3:0], empty);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = C_NOP;
    cmd_data    = '0;
    clear       = 1'b0;
    #12;
    test_reset();
    test_push_pop_replace();
    test_hold();
    test_overflow();
    test_underflow();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nibble_stack_writer.md
Name: nibble_stack_writer

Overview:
- Write side of the calculator's 8-slot nibble storage.
- Accepts push / pop / replace-top commands and maintains a LIFO of 4-bit values in DEPTH registered slots.
- Exposes every slot plus the top-of-stack index, so the existing 8:1 nibble selector can read any slot directly.
- Sits between the opcode decoder (command source) and the slot selector / ALU (consumers).

Parameters:
- WIDTH, 4, bits per slot.
- DEPTH, 8, number of slots; must be a power of two and at least 2.
- PTR_W, 3, index width, log2(DEPTH).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command strobe; the command is accepted on any clk edge where it is high.
- cmd_op  input  2  operation: 00 NOP, 01 PUSH, 10 POP, 11 REPLACE.
- cmd_data  input  WIDTH  value for PUSH / REPLACE.
- clear  input  1  synchronous flush; has priority over cmd_valid.
- slots  output  DEPTH*WIDTH  all slot registers; slot i occupies bits [i*WIDTH +: WIDTH].
- top  output  WIDTH  value of slot[depth-1]; 0 when empty.
- top_idx  output  PTR_W  depth-1 (mod DEPTH); 0 when empty. Selector index for the top of stack.
- depth  output  PTR_W+1  occupancy, 0..DEPTH.
- empty  output  1  depth==0.
- full  output  1  depth==DEPTH.
- overflow  output  1  sticky: PUSH attempted while full.
- underflow  output  1  sticky: POP or REPLACE attempted while empty.

Behaviour:
- Reset (async, immediate):
  - all slots=0, depth=0, overflow=0, underflow=0.
  - Hence top=0, top_idx=0, empty=1, full=0.
- All state updates occur on the rising clk edge in the cycle cmd_valid is sampled high. Effects are visible on outputs the following cycle (latency 1).
- top, top_idx, empty and full are combinational functions of the registered state only. No combinational path from cmd_* to any output.
- PUSH, not full: slot[depth] <= cmd_data; depth <= depth+1.
- PUSH, full: no slot or depth change; overflow <= 1.
- POP, not empty:
  - depth <= depth-1.
  - The vacated slot is cleared to 0, so the slots above the top always read 0.
- POP, empty: no change; underflow <= 1.
- REPLACE, not empty: slot[depth-1] <= cmd_data; depth unchanged.
- REPLACE, empty: no change; underflow <= 1.
- NOP, or cmd_valid low: hold all state.
- clear high: all slots=0, depth=0, overflow=0, underflow=0 on that edge. Any simultaneous command is discarded.
- Sticky flags clear only on reset or clear. A successful command never clears them.
- Wrap-around: depth never exceeds DEPTH and never goes below 0. top_idx is computed mod DEPTH but is forced to 0 when empty.
- Reset asserted mid-command: the async clear wins. The command in that cycle has no effect after reset deasserts.
- Back-to-back commands on consecutive cycles are fully supported. There is no busy state; every command completes in one cycle.

Decomposition:
- Shared package holds:
  - op encodings OP_NOP, OP_PUSH, OP_POP, OP_REPLACE;
  - the WIDTH default (4);
  - the DEPTH default (8).
- The package is also used by the opcode decoder.
- One natural sub-module: nibble_slot_reg. It is a single WIDTH-bit register with async reset, synchronous load enable and synchronous zero. It is instantiated DEPTH times under a generate loop, with per-slot load/zero enables decoded from depth and cmd_op.
- Pointer and flag logic stay in the top module.

Test Plan:
- Reset, then PUSH 0x3, 0x7, 0xA on consecutive cycles -> depth=3, top=0xA, top_idx=2, slots[11:0]=0xA73, empty=0.
- From that state: POP, then REPLACE 0x5 -> depth=2, top=0x5, slot2=0, slot1=0x5, slot0=0x3.
- Reset, PUSH 0x1..0x8 (8 pushes), then PUSH 0xF -> full=1, depth=8, slot7=0x8, overflow=1. Then POP -> depth=7, overflow still 1.
- Reset, POP, then REPLACE 0x9 -> depth=0, slots all 0, underflow=1, top=0, top_idx=0.
- Depth=4 with overflow=1; assert clear together with PUSH 0xC -> next cycle depth=0, all slots 0, overflow=0, underflow=0, and the push is discarded.
- Push 0x6 and assert reset asynchronously mid-cycle, before the clk edge -> outputs go to reset values immediately. After deassert, depth=0 and slot0=0.
